// File: rtl/updown_counter_ctrl_pkg.sv
// Shared constants and sizing helper for the up/down counter controller.
package updown_counter_ctrl_pkg;

  localparam logic RST_DIR_UP   = 1'b1;
  localparam logic RST_RUNNING  = 1'b1;
  localparam logic BTN_RELEASED = 1'b1;

  // Bits needed for a counter that runs 0..max_count-1 (never less than one bit).
  function automatic int cnt_width(input int max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/updown_counter_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability-count debounce and a one-cycle press pulse.
module btn_debounce
  import updown_counter_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CW = cnt_width(DB_CYCLES);

  logic          sync1_reg;
  logic          sync2_reg;
  logic [CW-1:0] stable_reg;
  logic          level_reg;
  logic          level_prev_reg;
  logic          press_reg;
  logic          blocked_reg;
  logic          stable_done;

  assign stable_done = (stable_reg == CW'(DB_CYCLES - 1));

  // The synchroniser keeps sampling through reset so a button held across reset
  // is seen as pressed and stays blocked until it is released.
  always_ff @(posedge clk) begin
    sync1_reg <= btn_n;
    sync2_reg <= sync1_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_reg     <= '0;
      level_reg      <= BTN_RELEASED;
      level_prev_reg <= BTN_RELEASED;
      press_reg      <= 1'b0;
      blocked_reg    <= 1'b1;
    end else begin
      level_prev_reg <= level_reg;
      press_reg      <= level_prev_reg & ~level_reg & ~blocked_reg;
      if (sync2_reg == BTN_RELEASED) begin
        blocked_reg <= 1'b0;
      end
      if (sync2_reg == level_reg) begin
        stable_reg <= '0;
      end else if (stable_done) begin
        stable_reg <= '0;
        level_reg  <= sync2_reg;
      end else begin
        stable_reg <= stable_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/updown_counter_ctrl.sv
// Up/down counter with selectable step rate, debounced direction/pause buttons, load and limit modes.
module updown_counter_ctrl
  import updown_counter_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DIV_SLOW  = 100_000_000,
  parameter int DIV_FAST  = 25_000_000,
  parameter int DB_CYCLES = 1_000_000,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             speed_sel,
  input  logic             btn_dir_n,
  input  logic             btn_stop_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             dir_up,
  output logic             running,
  output logic             step,
  output logic             at_limit
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int PW      = cnt_width(DIV_MAX);

  logic [PW-1:0]    presc_reg;
  logic [PW-1:0]    div_last;
  logic             speed_reg;
  logic             speed_change;
  logic             tick;
  logic [WIDTH-1:0] counter_reg;
  logic [WIDTH-1:0] counter_next;
  logic             step_reg;
  logic             step_next;
  logic             dir_reg;
  logic             running_reg;
  logic [1:0]       btn_n_vec;
  logic [1:0]       level_vec;
  logic [1:0]       press_vec;
  logic [1:0]       toggle_vec;

  // Index 0 is the direction button, index 1 the pause button.
  assign btn_n_vec = {btn_stop_n, btn_dir_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_db (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_n_vec[gi]),
        .level (level_vec[gi]),
        .press (press_vec[gi])
      );
      assign toggle_vec[gi] = press_vec[gi] & ~level_vec[gi];
    end
  endgenerate

  assign speed_change = speed_sel ^ speed_reg;
  assign div_last     = speed_sel ? PW'(DIV_FAST - 1) : PW'(DIV_SLOW - 1);
  assign tick         = ~speed_change & (presc_reg >= div_last);

  always_ff @(posedge clk) begin
    speed_reg <= speed_sel;
    if (rst || speed_change || tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  assign at_limit = dir_reg ? (&counter_reg) : ~(|counter_reg);

  always_comb begin
    counter_next = counter_reg;
    step_next    = 1'b0;
    if (load) begin
      counter_next = load_val;
    end else if (tick && running_reg) begin
      if (!(SATURATE && at_limit)) begin
        counter_next = dir_reg ? counter_reg + WIDTH'(1) : counter_reg - WIDTH'(1);
        step_next    = 1'b1;
      end
    end
  end

  // Flags toggle after the counter decision, so a press only affects later ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_reg <= '0;
      step_reg    <= 1'b0;
      dir_reg     <= RST_DIR_UP;
      running_reg <= RST_RUNNING;
    end else begin
      counter_reg <= counter_next;
      step_reg    <= step_next;
      dir_reg     <= dir_reg ^ toggle_vec[0];
      running_reg <= running_reg ^ toggle_vec[1];
    end
  end

  assign counter = counter_reg;
  assign dir_up  = dir_reg;
  assign running = running_reg;
  assign step    = step_reg;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Randomised bench for updown_counter_ctrl: wrap and saturate instances checked against a timing-rule model.
module tb_updown_counter_ctrl;

  localparam int DB   = 4;
  localparam int NMAX = 8192;

  logic       out_clk_tb = 1'b0;
  logic       rst        = 1'b1;
  logic       speed_sel  = 1'b0;
  logic       btn_dir_n  = 1'b1;
  logic       btn_stop_n = 1'b1;
  logic       load       = 1'b0;
  logic [3:0] load_val   = 4'd0;

  logic [3:0] counter0, counter1;
  logic       dir_up0, dir_up1, running0, running1, step0, step1, at_limit0, at_limit1;

  int errors = 0;
  int checks = 0;

  always #5 out_clk_tb = ~out_clk_tb;

  updown_counter_ctrl #(
    .WIDTH(4), .DIV_SLOW(8), .DIV_FAST(2), .DB_CYCLES(DB), .SATURATE(1'b0)
  ) u_wrap (
    .clk(out_clk_tb), .rst(rst), .speed_sel(speed_sel), .btn_dir_n(btn_dir_n),
    .btn_stop_n(btn_stop_n), .load(load), .load_val(load_val), .counter(counter0),
    .dir_up(dir_up0), .running(running0), .step(step0), .at_limit(at_limit0)
  );

  updown_counter_ctrl #(
    .WIDTH(4), .DIV_SLOW(8), .DIV_FAST(2), .DB_CYCLES(DB), .SATURATE(1'b1)
  ) u_sat (
    .clk(out_clk_tb), .rst(rst), .speed_sel(speed_sel), .btn_dir_n(btn_dir_n),
    .btn_stop_n(btn_stop_n), .load(load), .load_val(load_val), .counter(counter1),
    .dir_up(dir_up1), .running(running1), .step(step1), .at_limit(at_limit1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edge-numbered raw button samples, tick arithmetic from an anchor edge.
  int  n = 0;
  bit  sd [0:NMAX-1];
  bit  ss [0:NMAX-1];
  int  hist, anchor, m_cnt0, m_cnt1, div_m;
  bit  m_step0, m_step1, m_dir, m_run, last_speed, m_valid, tick_m, alld;
  bit  lvl [2];
  bit  blk [2];
  bit  tg  [2];
  int  tog_at [2];

  function automatic bit samp(input int b, input int i);
    return (b == 0) ? sd[i] : ss[i];
  endfunction

  always @(posedge out_clk_tb) begin
    n++;
    sd[n] = btn_dir_n;
    ss[n] = btn_stop_n;
    if (rst) begin
      m_cnt0 = 0; m_cnt1 = 0; m_step0 = 0; m_step1 = 0;
      m_dir = 1; m_run = 1; anchor = n; last_speed = speed_sel;
      hist = n - 1; m_valid = 1;
      for (int b = 0; b < 2; b++) begin
        lvl[b] = 1; blk[b] = 1; tog_at[b] = -1;
      end
    end else begin
      div_m = speed_sel ? 2 : 8;
      if (speed_sel != last_speed) begin
        anchor = n; last_speed = speed_sel; tick_m = 0;
      end else begin
        tick_m = ((n - anchor) % div_m) == 0;
      end
      for (int b = 0; b < 2; b++) tg[b] = (tog_at[b] == n);
      if (load) begin
        m_cnt0 = int'(load_val); m_cnt1 = int'(load_val); m_step0 = 0; m_step1 = 0;
      end else if (tick_m && m_run) begin
        m_cnt0  = m_dir ? (m_cnt0 + 1) % 16 : (m_cnt0 + 15) % 16;
        m_step0 = 1;
        if (m_dir ? (m_cnt1 == 15) : (m_cnt1 == 0)) begin
          m_step1 = 0;
        end else begin
          m_cnt1  = m_dir ? m_cnt1 + 1 : m_cnt1 - 1;
          m_step1 = 1;
        end
      end else begin
        m_step0 = 0; m_step1 = 0;
      end
      m_dir = m_dir ^ tg[0];
      m_run = m_run ^ tg[1];
      for (int b = 0; b < 2; b++) begin
        if (n - 2 >= hist && samp(b, n - 2)) blk[b] = 0;
        if (n - 1 - DB >= hist) begin
          alld = 1;
          for (int j = n - 1 - DB; j <= n - 2; j++) if (samp(b, j) == lvl[b]) alld = 0;
          if (alld) begin
            lvl[b] = ~lvl[b];
            if (!lvl[b] && !blk[b]) tog_at[b] = n + 2;
          end
        end
      end
    end
  end

  always @(negedge out_clk_tb) begin
    if (m_valid) begin
      chk("wrap_counter",  int'(counter0),  m_cnt0);
      chk("wrap_step",     int'(step0),     int'(m_step0));
      chk("wrap_dir_up",   int'(dir_up0),   int'(m_dir));
      chk("wrap_running",  int'(running0),  int'(m_run));
      chk("wrap_at_limit", int'(at_limit0), int'(m_dir ? (m_cnt0 == 15) : (m_cnt0 == 0)));
      chk("sat_counter",   int'(counter1),  m_cnt1);
      chk("sat_step",      int'(step1),     int'(m_step1));
      chk("sat_dir_up",    int'(dir_up1),   int'(m_dir));
      chk("sat_running",   int'(running1),  int'(m_run));
      chk("sat_at_limit",  int'(at_limit1), int'(m_dir ? (m_cnt1 == 15) : (m_cnt1 == 0)));
    end
  end

  task automatic step_n(input int k);
    repeat (k) @(negedge out_clk_tb);
  endtask

  task automatic pulse_load(input logic [3:0] v);
    load = 1'b1;
    load_val = v;
    $display("txn load val=%0d", v);
    step_n(1);
    load = 1'b0;
  endtask

  task automatic press_btn(input int b, input int len);
    $display("txn press %s for %0d cycles", (b == 0) ? "dir" : "stop", len);
    if (b == 0) btn_dir_n = 1'b0; else btn_stop_n = 1'b0;
    step_n(len);
    if (b == 0) btn_dir_n = 1'b1; else btn_stop_n = 1'b1;
  endtask

  int hold_d = 0;
  int hold_s = 0;
  int w;

  initial begin
    step_n(4);
    rst = 1'b0;
    $display("txn reset released");
    step_n(20);
    speed_sel = 1'b1;
    $display("txn speed fast");
    step_n(12);
    speed_sel = 1'b0;
    step_n(10);

    pulse_load(4'd5);
    press_btn(0, 10);
    step_n(20);
    press_btn(0, 3);
    step_n(20);

    press_btn(0, 10);
    step_n(5);
    pulse_load(4'd14);
    step_n(24);
    chk("sat_hold_counter", int'(counter1), 15);
    chk("sat_hold_limit", int'(at_limit1), 1);

    speed_sel = 1'b1;
    step_n(4);
    press_btn(1, 8);
    step_n(12);
    press_btn(1, 8);
    step_n(8);

    w = 0;
    while (((n + 1 - anchor) % 2) != 0 && w < 20) begin
      step_n(1);
      w++;
    end
    if (w >= 20) chk("tick_wait", w, 0);
    pulse_load(4'd9);
    chk("load_tick_counter", int'(counter0), 9);
    chk("load_tick_step", int'(step0), 0);
    step_n(6);

    speed_sel = 1'b0;
    press_btn(1, 8);
    step_n(2);
    if (m_dir) begin
      press_btn(0, 8);
      step_n(2);
    end
    pulse_load(4'd7);
    step_n(10);
    btn_stop_n = 1'b0;
    step_n(3);
    rst = 1'b1;
    $display("txn reset with stop held");
    step_n(1);
    chk("rst_counter", int'(counter0), 0);
    chk("rst_dir_up", int'(dir_up0), 1);
    chk("rst_running", int'(running0), 1);
    rst = 1'b0;
    step_n(20);
    btn_stop_n = 1'b1;
    step_n(10);
    press_btn(1, 8);
    step_n(10);

    $display("txn random phase");
    for (int i = 0; i < 1500; i++) begin
      if (hold_d > 0) begin
        hold_d--;
        if (hold_d == 0) btn_dir_n = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        btn_dir_n = 1'b0;
        hold_d = int'($urandom_range(1, 12));
      end
      if (hold_s > 0) begin
        hold_s--;
        if (hold_s == 0) btn_stop_n = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        btn_stop_n = 1'b0;
        hold_s = int'($urandom_range(1, 12));
      end
      load     = ($urandom_range(0, 29) == 0);
      load_val = 4'($urandom);
      if ($urandom_range(0, 99) == 0) speed_sel = ~speed_sel;
      rst = ($urandom_range(0, 499) == 0);
      step_n(1);
    end
    load = 1'b0;
    rst = 1'b0;
    step_n(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
